noc_out_arbiter: RTL and testbench
==================================

# noc_out_arbiter

Per-output-port switch arbiter for the 4-port router (L, N, W, S): selects one of the four input-port FIFO heads whose routed label targets this output, pops it, and forwards it as a registered flit. One instance per output port inside the switch-allocation stage. Allocation is wormhole: a head flit locks the output to its input until the tail flit passes. Downstream `full_in` gates every grant.

## Interface
- `DATASIZE`, 40, flit width: src[39:36], dst[35:32], timestamp[31:24], payload[23:2], type[1:0].
- `NPORT`, 4, number of requesting inputs. Fixed at 4; index 0=L, 1=N, 2=W, 3=S.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NPORT  req[i]=1: input i has a valid head flit whose label selects this output.
- `data_in`  in  NPORT*DATASIZE  flattened head flits; input i occupies [i*DATASIZE +: DATASIZE].
- `full_in`  in  1  downstream buffer full. Asserted while at least one slot is still free.
- `grant`  out  NPORT  one-hot or zero, combinational. grant[i] pops input i's FIFO this cycle.
- `data_out`  out  DATASIZE  registered flit.
- `valid_out`  out  1  registered one-cycle pulse per forwarded flit.
- `locked`  out  1  1 while in state LOCKED.
- `owner`  out  2  locked input index; 0 when IDLE.
- `proto_err`  out  1  sticky protocol-error flag.

## Operation
- Type encoding: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE.
- Round-robin pointer `ptr[1:0]`. The search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- No grant in any cycle where `full_in`=1, in either state.
- **IDLE** state:
  - The winner is the first requester in round-robin order.
  - HEAD flit granted: go to LOCKED, owner=winner. `ptr` is unchanged.
  - SINGLE flit granted: stay in IDLE, ptr=winner+1.
  - BODY or TAIL flit granted: forward it as a SINGLE flit, set `proto_err`, ptr=winner+1.
- **LOCKED** state:
  - Only req[owner] is considered. All other requests are ignored, with no grant.
  - BODY flit granted: stay in LOCKED.
  - TAIL flit granted: go to IDLE, ptr=owner+1, owner becomes 0.
  - HEAD or SINGLE flit from the owner: forward it, set `proto_err`, and stay in LOCKED.
  - If req[owner] is low, stay in LOCKED with no grant (bubbles are legal).
- `proto_err` clears only on reset.

## Timing
- Grant and pop happen in cycle T. In cycle T+1, `data_out`=data_in[winner] sampled at T and `valid_out`=1.
- Throughput is 1 flit/cycle. Back-to-back flits of one packet go out on consecutive cycles.
- `valid_out` falls in the cycle after the first cycle with no grant. `data_out` holds its last value when not valid.
- The state, ptr and owner updates take effect at the T+1 edge, so a new winner is selectable at T+1.
- `full_in` rising at T blocks the grant at T. The flit already launched at T-1 (valid at T) still completes, which is why `full_in` must assert with a slot free.
- Reset values:
  - Outputs: grant=0 (req ignored while rst_n=0), data_out=0, valid_out=0, locked=0, owner=0, proto_err=0.
  - Internal: state IDLE, ptr=0.
- Reset mid-packet drops the lock immediately. The downstream side must discard the partial packet.

## Configuration
- `ARB_AGE_PRIO_EN` defined: in IDLE, the winner is the requester with the oldest timestamp.
  - Flit a is older than flit b when (ts_b - ts_a) mod 256 lies in [1,127].
  - Ties and incomparable values fall back to round-robin order from ptr.
  - The pointer update rules are unchanged.
  - LOCKED behaviour is unchanged.
- Not defined: pure round-robin as above. No timestamp logic is synthesized.

## Structure
- Shared package `noc_pkg` holds:
  - flit field MSB/LSB constants (SRC, DST, TS, PAYLOAD, TYPE);
  - type encodings HEAD, BODY, TAIL, SINGLE;
  - port indices L=0, N=1, W=2, S=3;
  - the arbiter state enum {IDLE, LOCKED}.
- One sub-module, `rr_pick`: combinational rotating priority picker taking a 4-bit mask and a 2-bit start, returning a one-hot pick plus an index. It is reused by the age-priority tie-break.

## Test plan
- **Reset behaviour:** all req=1, all flits SINGLE, full_in=0.
  - rst_n low: grant stays 0.
  - After release, grants go 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and valid_out is continuously 1 from the second cycle.
- **Wormhole lock:** input N sends HEAD, BODY, BODY, TAIL while L and S request continuously.
  - grant=0010 for 4 cycles, locked=1 and owner=1 until after TAIL.
  - Then the next grant goes to W (if requesting), else to S (1000).
- **Backpressure:** full_in=1 for 3 cycles mid-packet.
  - grant=0 for those cycles, and valid_out drops one cycle later.
  - The packet resumes with the same owner, and no flit is lost or duplicated (check with a scoreboard).
- **Protocol error:** in IDLE, W presents a BODY flit.
  - The flit is forwarded, proto_err=1 and stays set, state remains IDLE, and ptr becomes 3.
- **Age priority:** with ARB_AGE_PRIO_EN, L ts=0x10, S ts=0x05, ptr=0 → S granted first.
  - With S ts=0x90 (wrap case, ts_L - ts_S mod 256 = 0x80, incomparable) → L is granted by round-robin.
- **Reset mid-packet:** assert rst_n low while LOCKED to N.
  - All outputs read 0 asynchronously.
  - After release, the first grant goes to L, given L requests.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router definitions: flit field layout, flit types, port indices,
// switch-arbiter state encoding and the timestamp age comparison.
package noc_pkg;

   localparam int FLIT_W      = 40;

   localparam int SRC_MSB     = 39;
   localparam int SRC_LSB     = 36;
   localparam int DST_MSB     = 35;
   localparam int DST_LSB     = 32;
   localparam int TS_MSB      = 31;
   localparam int TS_LSB      = 24;
   localparam int PAYLOAD_MSB = 23;
   localparam int PAYLOAD_LSB = 2;
   localparam int TYPE_MSB    = 1;
   localparam int TYPE_LSB    = 0;

   typedef enum logic [1:0] {
      BODY   = 2'b00,
      HEAD   = 2'b01,
      TAIL   = 2'b10,
      SINGLE = 2'b11
   } flit_type_e;

   localparam logic [1:0] PORT_L = 2'd0;
   localparam logic [1:0] PORT_N = 2'd1;
   localparam logic [1:0] PORT_W = 2'd2;
   localparam logic [1:0] PORT_S = 2'd3;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // a is older than b when b is 1..127 ticks ahead of a, modulo 256
   function automatic logic ts_older(input logic [7:0] a,
                                     input logic [7:0] b);
      logic [7:0] d;
      d = b - a;
      return (d != 8'd0) && !d[7];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of mask searching upward from
// start (mod 4), returned both one-hot and as an index.
module rr_pick (
   input  logic [3:0] mask,
   input  logic [1:0] start,
   output logic [3:0] pick,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] j;

   always_comb begin
      pick = '0;
      idx  = 2'd0;
      any  = 1'b0;
      j    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         j = start + k[1:0];
         if (!any && mask[j]) begin
            pick[j] = 1'b1;
            idx     = j;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output wormhole switch arbiter, round-robin with registered flit out.
// Define ARB_AGE_PRIO_EN to pick the oldest timestamp when idle.
module noc_out_arbiter
   import noc_pkg::*;
#(
   parameter int DATASIZE = 40,
   parameter int NPORT    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NPORT-1:0]          req,
   input  logic [NPORT*DATASIZE-1:0] data_in,
   input  logic                      full_in,
   output logic [NPORT-1:0]          grant,
   output logic [DATASIZE-1:0]       data_out,
   output logic                      valid_out,
   output logic                      locked,
   output logic [1:0]                owner,
   output logic                      proto_err
);

   arb_state_e          state_q, state_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [1:0]          owner_q, owner_d;
   logic [DATASIZE-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;

   logic [NPORT-1:0]    req_v;
   logic [3:0]          rr_pk;
   logic [1:0]          rr_idx;
   logic                rr_any;
   logic [3:0]          idle_pk;
   logic [1:0]          idle_idx;

   logic [1:0]          win;
   logic                go;
   logic [DATASIZE-1:0] flit;
   flit_type_e          ftype;

   // requests are meaningless while reset is held
   assign req_v = rst_n ? req : '0;

   rr_pick u_rr (
      .mask  (req_v),
      .start (ptr_q),
      .pick  (rr_pk),
      .idx   (rr_idx),
      .any   (rr_any)
   );

`ifdef ARB_AGE_PRIO_EN
   logic [7:0] ts [NPORT];
   logic [3:0] elig;
   logic [3:0] age_pk;
   logic [1:0] age_idx;
   logic       age_any;

   always_comb begin
      elig = req_v;
      for (int i = 0; i < NPORT; i++)
         ts[i] = data_in[i*DATASIZE+TS_LSB +: 8];
      for (int i = 0; i < NPORT; i++)
         for (int j = 0; j < NPORT; j++)
            if (j != i && req_v[j] && ts_older(ts[j], ts[i]))
               elig[i] = 1'b0;
   end

   rr_pick u_age (
      .mask  (elig),
      .start (ptr_q),
      .pick  (age_pk),
      .idx   (age_idx),
      .any   (age_any)
   );

   // wrap-around cycles can leave no oldest flit; fall back to round-robin
   always_comb begin
      idle_pk  = age_any ? age_pk : rr_pk;
      idle_idx = age_any ? age_idx : rr_idx;
   end
`else
   always_comb begin
      idle_pk  = rr_pk;
      idle_idx = rr_idx;
   end
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = err_q;
      grant   = '0;
      win     = 2'd0;
      go      = 1'b0;

      if (!full_in) begin
         if (state_q == IDLE) begin
            if (rr_any) begin
               grant = idle_pk;
               win   = idle_idx;
               go    = 1'b1;
            end
         end else if (req_v[owner_q]) begin
            grant[owner_q] = 1'b1;
            win            = owner_q;
            go             = 1'b1;
         end
      end

      flit  = data_in[win*DATASIZE +: DATASIZE];
      ftype = flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);

      if (go) begin
         data_d  = flit;
         valid_d = 1'b1;
         if (state_q == IDLE) begin
            unique case (ftype)
               HEAD: begin
                  state_d = LOCKED;
                  owner_d = win;
               end
               SINGLE: ptr_d = win + 2'd1;
               default: begin
                  err_d = 1'b1;
                  ptr_d = win + 2'd1;
               end
            endcase
         end else begin
            unique case (ftype)
               BODY: ;
               TAIL: begin
                  state_d = IDLE;
                  ptr_d   = owner_q + 2'd1;
                  owner_d = 2'd0;
               end
               default: err_d = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         owner_q <= 2'd0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign locked    = (state_q == LOCKED);
   assign owner     = owner_q;
   assign proto_err = err_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter: per-input source queues feed the DUT,
// expected grants are hand-computed, forwarded flits go through a scoreboard.
`timescale 1ns/1ps
module tb_noc_out_arbiter;
   import noc_pkg::*;

   localparam int DW = 40;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      req = '0;
   logic [4*DW-1:0] data_in = '0;
   logic            full_in = 1'b0;
   logic [3:0]      grant;
   logic [DW-1:0]   data_out;
   logic            valid_out;
   logic            locked;
   logic [1:0]      owner;
   logic            proto_err;

   noc_out_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .full_in   (full_in),
      .grant     (grant),
      .data_out  (data_out),
      .valid_out (valid_out),
      .locked    (locked),
      .owner     (owner),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   typedef logic [DW-1:0] fq_t [$];
   fq_t           srcq [4];
   logic [DW-1:0] sb [$];
   int            checks = 0;
   int            errors = 0;
   logic          prev_any = 1'b0;
   int            pay = 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic put(input int p, input logic [7:0] ts,
                      input logic [1:0] ty);
      logic [DW-1:0] f;
      f = {p[3:0], 4'd0, ts, pay[21:0], ty};
      pay++;
      srcq[p].push_back(f);
   endtask

   // one clock: present heads, check grant/valid, retire granted heads
   task automatic cyc(input logic [3:0] eg, input logic fb);
      for (int i = 0; i < 4; i++) begin
         req[i] = (srcq[i].size() != 0);
         data_in[i*DW +: DW] = req[i] ? srcq[i][0] : '0;
      end
      full_in = fb;
      @(negedge clk);
      chk("grant", {60'd0, grant}, {60'd0, eg});
      chk("valid_out", {63'd0, valid_out}, {63'd0, prev_any});
      for (int i = 0; i < 4; i++)
         if (eg[i] && srcq[i].size() != 0) begin
            sb.push_back(srcq[i][0]);
            void'(srcq[i].pop_front());
         end
      prev_any = (eg != 4'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && valid_out) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got %0h expected none", data_out);
         end else begin
            logic [DW-1:0] e;
            e = sb.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL sb_data: got %0h expected %0h", data_out, e);
            end
         end
      end
   end

   initial begin
      // reset: all inputs hold SINGLE flits, grant must stay 0
      for (int p = 0; p < 4; p++) begin
         put(p, 8'h00, SINGLE);
         put(p, 8'h00, SINGLE);
      end
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      chk("rst_data_out", {24'd0, data_out}, 64'd0);
      chk("rst_locked", {63'd0, locked}, 64'd0);
      chk("rst_owner", {62'd0, owner}, 64'd0);
      chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
      rst_n = 1'b1;
      cyc(4'b0001, 1'b0);
      cyc(4'b0010, 1'b0);
      cyc(4'b0100, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      cyc(4'b0010, 1'b0);
      cyc(4'b0100, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0000, 1'b0);

      // wormhole: N locks the output while L and S keep requesting
      put(0, 8'h00, SINGLE);
      cyc(4'b0001, 1'b0);
      put(1, 8'h00, HEAD);
      put(1, 8'h00, BODY);
      put(1, 8'h00, BODY);
      put(1, 8'h00, TAIL);
      put(0, 8'h00, SINGLE);
      put(0, 8'h00, SINGLE);
      put(3, 8'h00, SINGLE);
      put(3, 8'h00, SINGLE);
      cyc(4'b0010, 1'b0);
      chk("wh_locked", {63'd0, locked}, 64'd1);
      chk("wh_owner", {62'd0, owner}, 64'd1);
      cyc(4'b0010, 1'b0);
      cyc(4'b0010, 1'b0);
      chk("wh_locked_mid", {63'd0, locked}, 64'd1);
      cyc(4'b0010, 1'b0);
      chk("wh_unlocked", {63'd0, locked}, 64'd0);
      chk("wh_owner_idle", {62'd0, owner}, 64'd0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      cyc(4'b0000, 1'b0);

      // backpressure mid-packet from W, L ignored while locked
      put(2, 8'h00, HEAD);
      put(2, 8'h00, BODY);
      put(2, 8'h00, BODY);
      put(2, 8'h00, TAIL);
      put(0, 8'h00, SINGLE);
      cyc(4'b0100, 1'b0);
      cyc(4'b0100, 1'b0);
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b1);
      cyc(4'b0000, 1'b1);
      chk("bp_locked", {63'd0, locked}, 64'd1);
      chk("bp_owner", {62'd0, owner}, 64'd2);
      cyc(4'b0100, 1'b0);
      cyc(4'b0100, 1'b0);
      cyc(4'b0001, 1'b0);
      put(1, 8'h00, SINGLE);
      cyc(4'b0000, 1'b1);
      cyc(4'b0010, 1'b0);
      cyc(4'b0000, 1'b0);

      // protocol error: stray BODY from W while idle
      chk("pe_clean", {63'd0, proto_err}, 64'd0);
      put(2, 8'h00, BODY);
      cyc(4'b0100, 1'b0);
      chk("pe_set", {63'd0, proto_err}, 64'd1);
      chk("pe_idle", {63'd0, locked}, 64'd0);
      put(0, 8'h00, SINGLE);
      put(3, 8'h00, SINGLE);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      cyc(4'b0000, 1'b0);
      chk("pe_sticky", {63'd0, proto_err}, 64'd1);

      // reset while locked to N
      put(1, 8'h00, HEAD);
      put(1, 8'h00, BODY);
      put(1, 8'h00, BODY);
      put(1, 8'h00, TAIL);
      cyc(4'b0010, 1'b0);
      cyc(4'b0010, 1'b0);
      chk("mr_locked_before", {63'd0, locked}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_grant", {60'd0, grant}, 64'd0);
      chk("mr_data_out", {24'd0, data_out}, 64'd0);
      chk("mr_valid_out", {63'd0, valid_out}, 64'd0);
      chk("mr_locked", {63'd0, locked}, 64'd0);
      chk("mr_owner", {62'd0, owner}, 64'd0);
      chk("mr_proto_err", {63'd0, proto_err}, 64'd0);
      sb.delete();
      srcq[1].delete();
      prev_any = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int p = 0; p < 4; p++)
         put(p, 8'h00, SINGLE);
      cyc(4'b0001, 1'b0);
      cyc(4'b0010, 1'b0);
      cyc(4'b0100, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0000, 1'b0);

      // timestamp contest between L and S with ptr at 0
      put(0, 8'h10, SINGLE);
      put(3, 8'h05, SINGLE);
`ifdef ARB_AGE_PRIO_EN
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      put(3, 8'h00, SINGLE);
      cyc(4'b1000, 1'b0);
`else
      cyc(4'b0001, 1'b0);
      cyc(4'b1000, 1'b0);
`endif
      put(0, 8'h10, SINGLE);
      put(3, 8'h90, SINGLE);
      cyc(4'b0001, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      for (int p = 0; p < 4; p++)
         chk("src_drained", 64'(srcq[p].size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
